// File: rtl/pipe_stage_buf_if.sv
// Handshake bundle between a producer stage, the elastic stage buffer and a consumer stage.
// Signal suffixes are relative to the buffer, which uses the slave modport.
interface pipe_stage_buf_if #(
    parameter int DW = 56
);
    logic          in_valid_i;
    logic          in_ready_o;
    logic [DW-1:0] in_data_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [DW-1:0] out_data_o;

    modport master (
        output in_valid_i,
        output in_data_i,
        output out_ready_i,
        input  in_ready_o,
        input  out_valid_o,
        input  out_data_o
    );

    modport slave (
        input  in_valid_i,
        input  in_data_i,
        input  out_ready_i,
        output in_ready_o,
        output out_valid_o,
        output out_data_o
    );
endinterface

// File: rtl/pipe_stage_buf.sv
// DEPTH-entry elastic pipeline-stage FIFO with valid/ready on both sides and fc stall/flush.
// Stall freezes everything, flush empties and zeroes the buffer; bubbles carry a zero payload.
module pipe_stage_buf #(
    parameter int DW    = 56,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    pipe_stage_buf_if.slave bus,
    input  logic            fc_stall_i,
    input  logic            fc_flush_i,
    output logic [CW-1:0]   count_o
);
    localparam int            PW       = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [DEPTH-1:0][DW-1:0] mem_q;
    logic [DEPTH-1:0][DW-1:0] mem_d;
    logic [PW-1:0]            wr_ptr_q;
    logic [PW-1:0]            wr_ptr_d;
    logic [PW-1:0]            rd_ptr_q;
    logic [PW-1:0]            rd_ptr_d;
    logic [CW-1:0]            count_q;
    logic [CW-1:0]            count_d;
    logic                     run_s;
    logic                     in_ready_s;
    logic                     out_valid_s;
    logic                     push_s;
    logic                     pop_s;
    logic [DW-1:0]            head_s;

    // Explicit wrap so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        if (p == LAST_PTR) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1'b1);
        end
    endfunction

    // Handshake qualifiers; ready depends only on state and fc, never on out_ready_i.
    always_comb begin
        run_s       = !rst && !fc_stall_i && !fc_flush_i;
        in_ready_s  = run_s && (count_q < FULL_CNT);
        out_valid_s = run_s && (count_q != {CW{1'b0}});
        push_s      = bus.in_valid_i && in_ready_s;
        pop_s       = out_valid_s && bus.out_ready_i;
        if (count_q != {CW{1'b0}}) begin
            head_s = mem_q[rd_ptr_q];
        end else begin
            head_s = {DW{1'b0}};
        end
    end

    // Next-state: stall beats flush, flush beats normal push/pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (fc_stall_i) begin
            count_d = count_q;
        end else if (fc_flush_i) begin
            mem_d    = {(DEPTH * DW){1'b0}};
            wr_ptr_d = {PW{1'b0}};
            rd_ptr_d = {PW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (push_s) begin
                mem_d[wr_ptr_q] = bus.in_data_i;
                wr_ptr_d        = ptr_next(wr_ptr_q);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = ptr_next(rd_ptr_q);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CW'(1'b1);
                2'b01:   count_d = count_q - CW'(1'b1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers; reset drops all buffered content.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= {(DEPTH * DW){1'b0}};
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign bus.in_ready_o  = in_ready_s;
    assign bus.out_valid_o = out_valid_s;
    assign bus.out_data_o  = head_s;
    assign count_o         = count_q;

    pipe_stage_buf_chk #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_chk (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .count_i (count_q)
    );
endmodule

// Occupancy invariants of the stage buffer: never overflow, never underflow.
module pipe_stage_buf_chk #(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input logic          clk,
    input logic          rst,
    input logic          push_i,
    input logic          pop_i,
    input logic [CW-1:0] count_i
);
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push_i && (count_i == CW'(DEPTH))));

    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(pop_i && (count_i == {CW{1'b0}})));

    a_count_range: assert property (@(posedge clk) disable iff (rst)
        count_i <= CW'(DEPTH));
endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: DEPTH=2 instance for most scenarios, DEPTH=3 for wrap.
module tb_pipe_stage_buf;
    localparam int DW = 16;
    localparam logic [1:0] WPAT [18] = '{2'b11, 2'b10, 2'b10, 2'b10, 2'b01, 2'b11,
                                         2'b11, 2'b01, 2'b10, 2'b11, 2'b01, 2'b01,
                                         2'b01, 2'b10, 2'b11, 2'b11, 2'b00, 2'b00};

    logic       clk = 1'b0;
    logic       rst;
    logic       fc_stall;
    logic       fc_flush;
    logic [1:0] cnt2;
    logic [1:0] cnt3;
    int         vecs = 0;
    int         errs = 0;

    always #5 clk = ~clk;

    pipe_stage_buf_if #(.DW(DW)) b2 ();
    pipe_stage_buf_if #(.DW(DW)) b3 ();

    pipe_stage_buf #(.DW(DW), .DEPTH(2)) dut2 (
        .clk(clk), .rst(rst), .bus(b2), .fc_stall_i(fc_stall), .fc_flush_i(fc_flush), .count_o(cnt2));
    pipe_stage_buf #(.DW(DW), .DEPTH(3)) dut3 (
        .clk(clk), .rst(rst), .bus(b3), .fc_stall_i(fc_stall), .fc_flush_i(fc_flush), .count_o(cnt3));

    task automatic test_reset;
        #1;
        vecs++; if (cnt2 !== 2'd0) begin errs++; $display("FAIL rst_count got %0d want 0", cnt2); end
        vecs++; if (b2.out_valid_o !== 1'b0) begin errs++; $display("FAIL rst_valid got %b want 0", b2.out_valid_o); end
        vecs++; if (b2.in_ready_o !== 1'b0) begin errs++; $display("FAIL rst_ready got %b want 0", b2.in_ready_o); end
        @(negedge clk); rst = 1'b0; #1;
        vecs++; if (b2.in_ready_o !== 1'b1) begin errs++; $display("FAIL rst_rel_ready got %b want 1", b2.in_ready_o); end
        @(negedge clk); b2.in_valid_i = 1'b1; b2.in_data_i = 16'h00A1;
        @(negedge clk); b2.in_data_i = 16'h00A2;
        @(negedge clk); b2.in_valid_i = 1'b0;
        vecs++; if (cnt2 !== 2'd2) begin errs++; $display("FAIL pre_rst_count got %0d want 2", cnt2); end
        rst = 1'b1; #1;
        vecs++; if (cnt2 !== 2'd0) begin errs++; $display("FAIL mid_rst_count got %0d want 0", cnt2); end
        vecs++; if (b2.out_valid_o !== 1'b0) begin errs++; $display("FAIL mid_rst_valid got %b want 0", b2.out_valid_o); end
        vecs++; if (b2.out_data_o !== 16'h0000) begin errs++; $display("FAIL mid_rst_data got %h want 0000", b2.out_data_o); end
        vecs++; if (b2.in_ready_o !== 1'b0) begin errs++; $display("FAIL mid_rst_ready got %b want 0", b2.in_ready_o); end
        @(negedge clk); rst = 1'b0; #1;
        vecs++; if (b2.in_ready_o !== 1'b1) begin errs++; $display("FAIL post_rst_ready got %b want 1", b2.in_ready_o); end
        vecs++; if (b2.out_valid_o !== 1'b0) begin errs++; $display("FAIL post_rst_valid got %b want 0", b2.out_valid_o); end
    endtask

    task automatic test_stream;
        b2.out_ready_i = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i > 1) begin
                vecs++; if (b2.out_valid_o !== 1'b1) begin errs++; $display("FAIL stream_valid[%0d] got %b want 1", i, b2.out_valid_o); end
                vecs++; if (b2.out_data_o !== 16'(i - 1)) begin errs++; $display("FAIL stream_data[%0d] got %h want %h", i, b2.out_data_o, 16'(i - 1)); end
                vecs++; if (cnt2 !== 2'd1) begin errs++; $display("FAIL stream_count[%0d] got %0d want 1", i, cnt2); end
            end
            vecs++; if (b2.in_ready_o !== 1'b1) begin errs++; $display("FAIL stream_ready[%0d] got %b want 1", i, b2.in_ready_o); end
            b2.in_valid_i = 1'b1; b2.in_data_i = 16'(i);
        end
        @(negedge clk);
        vecs++; if (b2.out_data_o !== 16'h0010) begin errs++; $display("FAIL stream_last got %h want 0010", b2.out_data_o); end
        b2.in_valid_i = 1'b0;
        @(negedge clk);
        vecs++; if (cnt2 !== 2'd0) begin errs++; $display("FAIL stream_drain got %0d want 0", cnt2); end
        vecs++; if (b2.out_data_o !== 16'h0000) begin errs++; $display("FAIL stream_bubble got %h want 0000", b2.out_data_o); end
    endtask

    task automatic test_backpressure;
        b2.out_ready_i = 1'b0;
        @(negedge clk); b2.in_valid_i = 1'b1; b2.in_data_i = 16'h00AA;
        @(negedge clk); b2.in_data_i = 16'h00BB;
        @(negedge clk); b2.in_data_i = 16'h00CC;
        vecs++; if (cnt2 !== 2'd2) begin errs++; $display("FAIL bp_full_count got %0d want 2", cnt2); end
        vecs++; if (b2.in_ready_o !== 1'b0) begin errs++; $display("FAIL bp_full_ready got %b want 0", b2.in_ready_o); end
        @(negedge clk);
        vecs++; if (cnt2 !== 2'd2) begin errs++; $display("FAIL bp_hold_count got %0d want 2", cnt2); end
        vecs++; if (b2.out_data_o !== 16'h00AA) begin errs++; $display("FAIL bp_head_a got %h want 00AA", b2.out_data_o); end
        b2.out_ready_i = 1'b1;
        @(negedge clk);
        vecs++; if (cnt2 !== 2'd1) begin errs++; $display("FAIL bp_pop_a_count got %0d want 1", cnt2); end
        vecs++; if (b2.out_data_o !== 16'h00BB) begin errs++; $display("FAIL bp_head_b got %h want 00BB", b2.out_data_o); end
        vecs++; if (b2.in_ready_o !== 1'b1) begin errs++; $display("FAIL bp_ready_again got %b want 1", b2.in_ready_o); end
        @(negedge clk);
        vecs++; if (b2.out_data_o !== 16'h00CC) begin errs++; $display("FAIL bp_head_c got %h want 00CC", b2.out_data_o); end
        vecs++; if (cnt2 !== 2'd1) begin errs++; $display("FAIL bp_c_count got %0d want 1", cnt2); end
        b2.in_valid_i = 1'b0;
        @(negedge clk);
        vecs++; if (b2.out_valid_o !== 1'b0) begin errs++; $display("FAIL bp_empty_valid got %b want 0", b2.out_valid_o); end
    endtask

    task automatic test_flush;
        b2.out_ready_i = 1'b0;
        @(negedge clk); b2.in_valid_i = 1'b1; b2.in_data_i = 16'h00A1;
        @(negedge clk); b2.in_data_i = 16'h00B2;
        @(negedge clk);
        vecs++; if (cnt2 !== 2'd2) begin errs++; $display("FAIL fl_pre_count got %0d want 2", cnt2); end
        b2.in_data_i = 16'h00DD; fc_flush = 1'b1; #1;
        vecs++; if (b2.in_ready_o !== 1'b0) begin errs++; $display("FAIL fl_ready got %b want 0", b2.in_ready_o); end
        vecs++; if (b2.out_valid_o !== 1'b0) begin errs++; $display("FAIL fl_valid got %b want 0", b2.out_valid_o); end
        @(negedge clk); fc_flush = 1'b0; b2.in_valid_i = 1'b0;
        vecs++; if (cnt2 !== 2'd0) begin errs++; $display("FAIL fl_count got %0d want 0", cnt2); end
        vecs++; if (b2.out_valid_o !== 1'b0) begin errs++; $display("FAIL fl_post_valid got %b want 0", b2.out_valid_o); end
        vecs++; if (b2.out_data_o !== 16'h0000) begin errs++; $display("FAIL fl_data got %h want 0000", b2.out_data_o); end
    endtask

    task automatic test_stall_flush;
        @(negedge clk); b2.in_valid_i = 1'b1; b2.in_data_i = 16'h00E5; b2.out_ready_i = 1'b0;
        @(negedge clk);
        b2.in_data_i = 16'h00F6; fc_stall = 1'b1; fc_flush = 1'b1; b2.out_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vecs++; if (cnt2 !== 2'd1) begin errs++; $display("FAIL sf_count[%0d] got %0d want 1", k, cnt2); end
            vecs++; if (b2.in_ready_o !== 1'b0) begin errs++; $display("FAIL sf_ready[%0d] got %b want 0", k, b2.in_ready_o); end
            vecs++; if (b2.out_valid_o !== 1'b0) begin errs++; $display("FAIL sf_valid[%0d] got %b want 0", k, b2.out_valid_o); end
            vecs++; if (b2.out_data_o !== 16'h00E5) begin errs++; $display("FAIL sf_data[%0d] got %h want 00E5", k, b2.out_data_o); end
        end
        fc_stall = 1'b0; #1;
        vecs++; if (b2.out_valid_o !== 1'b0) begin errs++; $display("FAIL sf_flush_valid got %b want 0", b2.out_valid_o); end
        @(negedge clk); fc_flush = 1'b0; b2.in_valid_i = 1'b0; b2.out_ready_i = 1'b0;
        vecs++; if (cnt2 !== 2'd0) begin errs++; $display("FAIL sf_cleared got %0d want 0", cnt2); end
        vecs++; if (b2.out_data_o !== 16'h0000) begin errs++; $display("FAIL sf_cleared_data got %h want 0000", b2.out_data_o); end
    endtask

    task automatic test_wrap;
        logic [DW-1:0] q[$];
        logic [DW-1:0] ed;
        logic [1:0]    p;
        logic          do_push;
        logic          do_pop;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            ed = (q.size() != 0) ? q[0] : 16'h0000;
            vecs++; if (cnt3 !== 2'(q.size())) begin errs++; $display("FAIL wrap_count[%0d] got %0d want %0d", i, cnt3, q.size()); end
            vecs++; if (b3.out_valid_o !== (q.size() != 0)) begin errs++; $display("FAIL wrap_valid[%0d] got %b", i, b3.out_valid_o); end
            vecs++; if (b3.out_data_o !== ed) begin errs++; $display("FAIL wrap_data[%0d] got %h want %h", i, b3.out_data_o, ed); end
            vecs++; if (b3.in_ready_o !== (q.size() < 3)) begin errs++; $display("FAIL wrap_ready[%0d] got %b", i, b3.in_ready_o); end
            p = WPAT[i];
            b3.in_valid_i  = p[1];
            b3.out_ready_i = p[0];
            b3.in_data_i   = 16'h0030 + 16'(i);
            do_push = p[1] && (q.size() < 3);
            do_pop  = p[0] && (q.size() != 0);
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(b3.in_data_i);
        end
        b3.in_valid_i = 1'b0; b3.out_ready_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1; fc_stall = 1'b0; fc_flush = 1'b0;
        b2.in_valid_i = 1'b0; b2.in_data_i = 16'h0000; b2.out_ready_i = 1'b0;
        b3.in_valid_i = 1'b0; b3.in_data_i = 16'h0000; b3.out_ready_i = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_stall_flush();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
